seg_time_mux: RTL



---
 rtl/seg_time_mux_pkg.sv | 30 +++
 rtl/seven_seg_decoder.sv | 14 +
 rtl/seg_time_mux.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/seg_time_mux_pkg.sv
// seg_time_mux_pkg: shared types and constants for the two-digit seven-segment
// time multiplexer and the reusable hex decoder.
//   state_e    : display phase (blank before digit 0, show 0, blank before 1, show 1)
//   SEG_OFF    : active-low segment pattern with every segment dark
//   SegTable   : hex digit -> active-low {g,f,e,d,c,b,a}, indexed by the digit value
//   max_u      : larger of two unsigned values, used for counter sizing
package seg_time_mux_pkg;

  typedef enum logic [1:0] {
    StBlank0 = 2'd0,
    StShow0  = 2'd1,
    StBlank1 = 2'd2,
    StShow1  = 2'd3
  } state_e;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Packed so that element [n] is the pattern for hex digit n (listed F down to 0).
  localparam logic [15:0][6:0] SegTable = {
    7'h0E, 7'h06, 7'h21, 7'h46,  // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,  // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,  // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40   // 3 2 1 0
  };

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// seven_seg_decoder: purely combinational hex to seven-segment decoder.
// Shared with other labs; output is active-low, bit order {g,f,e,d,c,b,a}.
//   hex_i   [3:0] : hex digit to display
//   seg_n_o [6:0] : active-low segment pattern
module seven_seg_decoder
  import seg_time_mux_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_n_o
);

  assign seg_n_o = SegTable[hex_i];

endmodule

// File: rtl/seg_time_mux.sv
// seg_time_mux: drives a dual common-anode seven-segment display from one shared
// active-low segment bus. The two digits alternate, each shown for DWELL_CYCLES
// clocks, with BLANK_CYCLES clocks of both anodes off in between so the bus never
// changes under a lit anode. Sequence: blank0 -> show0 -> blank1 -> show1 -> blank0.
// All outputs are registered.
//
// Ports:
//   clk        : system clock
//   reset      : synchronous, active-low reset
//   s0, s1     : hex digits for display 0 and display 1
//   seg [6:0]  : segment bus {g,f,e,d,c,b,a}, active-low
//   an0, an1   : anode enables for display 0 / 1, active-low
//
// Build option SEG_TIME_MUX_SAMPLE_HOLD_EN: when defined, each digit is captured on
// the edge entering its show phase and held for the whole dwell; when undefined the
// bus follows the live input with one clock of latency.
module seg_time_mux
  import seg_time_mux_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = 40000,
  parameter int unsigned BLANK_CYCLES = 2000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] s0,
  input  logic [3:0] s1,
  output logic [6:0] seg,
  output logic       an0,
  output logic       an1
);

  localparam int unsigned CntMax = max_u(DWELL_CYCLES, BLANK_CYCLES);
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [CntW-1:0] DwellLast = CntW'(DWELL_CYCLES - 1);
  localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYCLES - 1);

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [6:0]      seg_q;
  logic            an0_q;
  logic            an1_q;

  logic [CntW-1:0] phase_last;
  logic            phase_done;
  logic [3:0]      digit;
  logic [6:0]      digit_seg;

  // Last count value of the current phase; the counter clears on every phase change.
  always_comb begin
    phase_last = BlankLast;
    if (state_q == StShow0 || state_q == StShow1) begin
      phase_last = DwellLast;
    end
  end

  assign phase_done = (cnt_q == phase_last);

`ifdef SEG_TIME_MUX_SAMPLE_HOLD_EN
  logic [3:0] hold0_q;
  logic [3:0] hold1_q;

  // Capture on the edge that moves the FSM into the matching show phase, so the
  // value is stable before the anode is driven low on the following edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hold0_q <= 4'h0;
      hold1_q <= 4'h0;
    end else begin
      if (state_q == StBlank0 && phase_done) begin
        hold0_q <= s0;
      end
      if (state_q == StBlank1 && phase_done) begin
        hold1_q <= s1;
      end
    end
  end

  always_comb begin
    digit = hold0_q;
    if (state_q == StShow1) begin
      digit = hold1_q;
    end
  end
`else
  always_comb begin
    digit = s0;
    if (state_q == StShow1) begin
      digit = s1;
    end
  end
`endif

  seven_seg_decoder u_decoder (
    .hex_i   (digit),
    .seg_n_o (digit_seg)
  );

  // Outputs are registered from the current state, so they trail the state by one
  // clock: an anode falls on the edge after the FSM enters a show phase and rises on
  // the edge after it leaves, together with the bus returning to SEG_OFF.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StBlank0;
      cnt_q   <= '0;
      seg_q   <= SEG_OFF;
      an0_q   <= 1'b1;
      an1_q   <= 1'b1;
    end else begin
      unique case (state_q)
        StShow0: begin
          seg_q <= digit_seg;
          an0_q <= 1'b0;
          an1_q <= 1'b1;
        end
        StShow1: begin
          seg_q <= digit_seg;
          an0_q <= 1'b1;
          an1_q <= 1'b0;
        end
        default: begin
          seg_q <= SEG_OFF;
          an0_q <= 1'b1;
          an1_q <= 1'b1;
        end
      endcase

      if (phase_done) begin
        cnt_q <= '0;
        unique case (state_q)
          StBlank0: state_q <= StShow0;
          StShow0:  state_q <= StBlank1;
          StBlank1: state_q <= StShow1;
          default:  state_q <= StBlank0;
        endcase
      end else begin
        cnt_q <= cnt_q + CntW'(1);
      end
    end
  end

  assign seg = seg_q;
  assign an0 = an0_q;
  assign an1 = an1_q;

endmodule
